tile_draw_arbiter: RTL and testbench
====================================

// Module: tile_draw_arbiter
// PURPOSE
//   Shares the single vga_adapter pixel-write port (plot/x/y/colour) among NREQ tile requesters:
//   snake head draw, tail erase and apple draw. Each request is one XDIM x YDIM filled square.
//   Arbitrates round-robin, then raster-fills the granted square at one pixel per clock.
//   Returns a one-cycle done pulse to the winner. Sits between the game FSM and vga_adapter.
// PARAMETERS
//   NREQ    3    number of requesters (index 0 = highest after reset)
//   XDIM    10   square width, pixels
//   YDIM    10   square height, pixels
//   XSCREEN 160  visible width; pixels with x >= XSCREEN are suppressed
//   YSCREEN 120  visible height; pixels with y >= YSCREEN are suppressed
// PORTS
//   Clock      in   1        system clock (CLOCK_50)
//   Resetn     in   1        synchronous, active-low reset
//   req        in   NREQ     per-requester request level; hold until matching done
//   req_x      in   8*NREQ   square origin x; slice i = [8*i+7:8*i]
//   req_y      in   7*NREQ   square origin y; slice i = [7*i+6:7*i]
//   req_colour in   3*NREQ   fill colour; slice i = [3*i+2:3*i]
//   grant      out  NREQ     one-hot owner, high for the whole fill
//   done       out  NREQ     one-cycle pulse to owner after its last pixel
//   busy       out  1        high in FILL and DONE
//   plot       out  1        pixel-write strobe to vga_adapter
//   x          out  8        pixel x
//   y          out  7        pixel y
//   colour     out  3        pixel colour
// BEHAVIOUR
//   - Reset (Resetn=0 at posedge): state=IDLE, rr pointer=0. grant, done, busy, plot, x, y and colour are all 0.
//     Reset mid-fill aborts the fill silently; no done is issued.
//   - All outputs are registered.
//   - States: IDLE -> FILL -> DONE -> IDLE.
//   - IDLE: if |req, pick the winner with a round-robin search starting at ptr.
//     Latch origin and colour, set grant and busy, set XC=YC=0, go to FILL.
//     If no req, stay in IDLE with all strobes low.
//   - FILL: each cycle x = ox+XC and y = oy+YC, colour is the latched value.
//     plot=1 unless the 9-bit sum ox+XC >= XSCREEN or the 8-bit sum oy+YC >= YSCREEN. A clipped pixel still uses its cycle.
//     XC increments each cycle. At XC==XDIM-1, XC wraps to 0 and YC increments.
//     At XC==XDIM-1 and YC==YDIM-1, go to DONE.
//   - DONE: done[g]=1 for exactly one cycle and plot=0. grant clears at exit.
//     ptr <= (g+1) mod NREQ. Go to IDLE. req is not sampled in DONE.
//   - Latency: req sampled in IDLE -> grant and first pixel on the next cycle.
//     A fill lasts XDIM*YDIM cycles; done follows in the cycle after the last pixel.
//     Back-to-back service costs XDIM*YDIM+2 cycles per square.
//   - Handshake: a requester drops req in the cycle it sees done.
//     A req still high in IDLE after done is treated as a new request.
//     Dropping req mid-fill is ignored: the fill completes and done still pulses.
//     req_x, req_y and req_colour are sampled only at grant; later changes have no effect.
//   - Simultaneous requests: one winner per arbitration; losers wait with grant=0.
//     No starvation: every requester is served within NREQ fills.
// STRUCTURE
//   - Shared package (snake_pkg): XDIM, YDIM, XSCREEN, YSCREEN, COLOUR_W=3, X_W=8, Y_W=7, state encoding.
//   - Sub-module rr_pick: combinational round-robin, (req, ptr) -> one-hot winner and index.
//   - XC and YC are UpDn_count instances with load-to-0 and up-count enable.
// TESTING
//   1. Reset: hold Resetn=0 for 3 cycles with req=3'b111 -> all outputs 0 and no grant. Release -> grant=001 on the next cycle.
//   2. Single fill: req0 with origin (80,60) and colour 3'b100 ->
//      100 plot pulses covering x 80..89 and y 60..69 in raster order, colour 100.
//      done[0] comes 1 cycle after (89,69).
//   3. Contention: req=3'b111 held, each requester dropping on its done -> grants 001, 010, 100 in order, each 102 cycles apart.
//   4. Clipping: req1 with origin (155,115) -> 100 fill cycles with 25 plots (x 155..159, y 115..119). done[1] still pulses.
//   5. Abort: Resetn=0 at fill cycle 37 -> plot=0 next cycle, no done, IDLE.
//      A held req is re-granted 1 cycle after Resetn=1.
//   6. Mid-fill change: change req_x and colour and drop req during the fill -> pixels keep the latched values and done still pulses.

Source files
------------

// File: rtl/tile_draw_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the tile draw arbiter.
// Default geometry matches the 160x120 vga_adapter with 10x10 tiles.
package tile_draw_arbiter_pkg;

    localparam int TILE_NREQ = 3;
    localparam int TILE_XDIM = 10;
    localparam int TILE_YDIM = 10;
    localparam int SCREEN_X  = 160;
    localparam int SCREEN_Y  = 120;
    localparam int COLOUR_W  = 3;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Sums are one bit wider than the pixel bus so overflow past the edge is still clipped.
    function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy,
                                       input int xs, input int ys);
        return (int'(sx) < xs) && (int'(sy) < ys);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_draw_arbiter_if.sv
// Requester bundle plus the vga_adapter pixel-write port shared by the arbiter.
// Requester slices are packed: slice i of req_x is [X_W*i +: X_W], and likewise for y/colour.
interface tile_draw_arbiter_if
    import tile_draw_arbiter_pkg::*;
#(
    parameter int NREQ = TILE_NREQ
);
    logic [NREQ-1:0]          req;
    logic [X_W*NREQ-1:0]      req_x;
    logic [Y_W*NREQ-1:0]      req_y;
    logic [COLOUR_W*NREQ-1:0] req_colour;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          done;
    logic                     busy;
    logic                     plot;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [COLOUR_W-1:0]      colour;

    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, busy, plot, x, y, colour
    );

    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, busy, plot, x, y, colour
    );
endinterface

// File: rtl/tile_draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    int   sel;
    logic hit;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        sel   = 0;
        for (int k = 0; k < NREQ; k++) begin
            sel = (int'(ptr_i) + k) % NREQ;
            if (!hit && req_i[sel]) begin
                hit        = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = IW'(sel);
            end
        end
        any_o = hit;
    end
endmodule

// File: rtl/tile_draw_arbiter_updn_count.sv
// Up/down counter with synchronous clear-load; used for the tile column and row offsets.
module UpDn_count #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic         up_i,
    input  logic         dn_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (up_i && !dn_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (dn_i && !up_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/tile_draw_arbiter.sv
// Round-robin owner of the vga_adapter write port; raster-fills one XDIM x YDIM tile per grant.
// All outputs are registered; the pixel shown on x/y is the one addressed by the XC/YC counters.
module tile_draw_arbiter
    import tile_draw_arbiter_pkg::*;
#(
    parameter int NREQ    = TILE_NREQ,
    parameter int XDIM    = TILE_XDIM,
    parameter int YDIM    = TILE_YDIM,
    parameter int XSCREEN = SCREEN_X,
    parameter int YSCREEN = SCREEN_Y
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    tile_draw_arbiter_if.slave   bus
);
    localparam int IW   = cnt_w(NREQ);
    localparam int XC_W = cnt_w(XDIM);
    localparam int YC_W = cnt_w(YDIM);

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [NREQ-1:0]      done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 plot_q, plot_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [COLOUR_W-1:0]  colour_q, colour_d;
    logic [X_W-1:0]       ox_q, ox_d;
    logic [Y_W-1:0]       oy_q, oy_d;
    logic [COLOUR_W-1:0]  col_q, col_d;

    logic [NREQ-1:0]      win_oh;
    logic [IW-1:0]        win_idx;
    logic                 win_any;
    logic [XC_W-1:0]      xc, px_xc;
    logic [YC_W-1:0]      yc, px_yc;
    logic                 xc_load, xc_up, yc_load, yc_up;
    logic                 pix_en;
    logic [X_W:0]         sum_x;
    logic [Y_W:0]         sum_y;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    UpDn_count #(.W(XC_W)) u_xc (
        .clk_i  (Clock),
        .rstn_i (Resetn),
        .load_i (xc_load),
        .up_i   (xc_up),
        .dn_i   (1'b0),
        .cnt_o  (xc)
    );

    UpDn_count #(.W(YC_W)) u_yc (
        .clk_i  (Clock),
        .rstn_i (Resetn),
        .load_i (yc_load),
        .up_i   (yc_up),
        .dn_i   (1'b0),
        .cnt_o  (yc)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        col_d    = col_q;
        xc_load  = 1'b0;
        xc_up    = 1'b0;
        yc_load  = 1'b0;
        yc_up    = 1'b0;
        px_xc    = '0;
        px_yc    = '0;
        pix_en   = 1'b0;
        sum_x    = '0;
        sum_y    = '0;

        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (win_any) begin
                    grant_d = win_oh;
                    gidx_d  = win_idx;
                    busy_d  = 1'b1;
                    ox_d    = bus.req_x[int'(win_idx)*X_W +: X_W];
                    oy_d    = bus.req_y[int'(win_idx)*Y_W +: Y_W];
                    col_d   = bus.req_colour[int'(win_idx)*COLOUR_W +: COLOUR_W];
                    xc_load = 1'b1;
                    yc_load = 1'b1;
                    pix_en  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // Counters hold the pixel on the bus now; compute the one to show next.
                pix_en = 1'b1;
                px_yc  = yc;
                if (xc == XC_W'(XDIM - 1)) begin
                    if (yc == YC_W'(YDIM - 1)) begin
                        pix_en  = 1'b0;
                        done_d  = grant_q;
                        state_d = ST_DONE;
                    end else begin
                        xc_load = 1'b1;
                        yc_up   = 1'b1;
                        px_xc   = '0;
                        px_yc   = yc + YC_W'(1);
                    end
                end else begin
                    xc_up = 1'b1;
                    px_xc = xc + XC_W'(1);
                end
            end
            ST_DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pix_en) begin
            sum_x    = (X_W+1)'(ox_d) + (X_W+1)'(px_xc);
            sum_y    = (Y_W+1)'(oy_d) + (Y_W+1)'(px_yc);
            plot_d   = on_screen(sum_x, sum_y, XSCREEN, YSCREEN);
            x_d      = sum_x[X_W-1:0];
            y_d      = sum_y[Y_W-1:0];
            colour_d = col_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    // Tile origin and colour are only meaningful while a grant is held.
    always_ff @(posedge Clock) begin
        ox_q  <= ox_d;
        oy_q  <= oy_d;
        col_q <= col_d;
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.plot   = plot_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// Bench for tile_draw_arbiter: scoreboard of expected pixels/done pulses plus a table of single fills.
module tb_tile_draw_arbiter;

    localparam int FILL_CYC = 100;

    typedef struct {
        int         idx;
        int         ox;
        int         oy;
        logic [2:0] col;
        int         plots;
    } vec_t;

    logic Clock;
    logic Resetn;

    tile_draw_arbiter_if #(.NREQ(3)) bus ();

    tile_draw_arbiter dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          errs = 0;
    int          checks = 0;
    logic [17:0] exp_pix[$];
    logic [2:0]  exp_done[$];
    vec_t        vecs[7];
    int          gstart[3];
    logic [2:0]  gval[3];
    int          ng;
    logic [2:0]  prev_g;
    bit          fin;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference raster model: first maxn positions of the tile, visible pixels only.
    task automatic push_square(input int ox, input int oy, input logic [2:0] col, input int maxn);
        int n = 0;
        for (int yc = 0; yc < 10; yc++) begin
            for (int xc = 0; xc < 10; xc++) begin
                if (n < maxn && (ox + xc) < 160 && (oy + yc) < 120) begin
                    exp_pix.push_back({8'(ox + xc), 7'(oy + yc), col});
                end
                n++;
            end
        end
    endtask

    always @(negedge Clock) begin
        logic [17:0] p;
        logic [2:0]  d;
        if (bus.plot === 1'b1) begin
            if (exp_pix.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL pixel_unexpected: got %0h expected none", {bus.x, bus.y, bus.colour});
            end else begin
                p = exp_pix.pop_front();
                chk("pixel", {14'b0, bus.x, bus.y, bus.colour}, {14'b0, p});
            end
        end
        if (bus.done !== 3'b000) begin
            if (exp_done.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL done_unexpected: got %0h expected none", bus.done);
            end else begin
                d = exp_done.pop_front();
                chk("done_pulse", {29'b0, bus.done}, {29'b0, d});
            end
        end
    end

    task automatic track_fill(input int idx, input int plots, input int change_at, input string nm);
        int cyc = 0;
        int np = 0;
        bit seen = 0;
        for (int n = 0; n < 300; n++) begin
            if (bus.done != 3'b000) begin
                seen = 1;
                break;
            end
            cyc++;
            if (bus.plot) np++;
            if (cyc == change_at) begin
                bus.req_x[8*idx +: 8]      = 8'd5;
                bus.req_y[7*idx +: 7]      = 7'd3;
                bus.req_colour[3*idx +: 3] = 3'b110;
                bus.req[idx]               = 1'b0;
            end
            @(negedge Clock);
        end
        if (!seen) begin
            checks++;
            errs++;
            $display("FAIL %s_timeout: got no done expected done within 300 cycles", nm);
        end
        chk({nm, "_done"}, {29'b0, bus.done}, 32'(1 << idx));
        chk({nm, "_grant_at_done"}, {29'b0, bus.grant}, 32'(1 << idx));
        chk({nm, "_busy_at_done"}, {31'b0, bus.busy}, 32'd1);
        chk({nm, "_fill_cycles"}, cyc, FILL_CYC);
        chk({nm, "_plots"}, np, plots);
        bus.req[idx] = 1'b0;
        @(negedge Clock);
        chk({nm, "_idle"}, {24'b0, bus.grant, bus.done, bus.busy, bus.plot}, 32'd0);
        chk({nm, "_queue"}, exp_pix.size() + exp_done.size(), 32'd0);
    endtask

    task automatic run_fill(input int idx, input int ox, input int oy, input logic [2:0] col,
                            input int plots, input int change_at, input string nm);
        @(negedge Clock);
        bus.req_x[8*idx +: 8]      = 8'(ox);
        bus.req_y[7*idx +: 7]      = 7'(oy);
        bus.req_colour[3*idx +: 3] = col;
        push_square(ox, oy, col, 100);
        exp_done.push_back(3'(1 << idx));
        bus.req[idx] = 1'b1;
        @(negedge Clock);
        chk({nm, "_grant"}, {29'b0, bus.grant}, 32'(1 << idx));
        track_fill(idx, plots, change_at, nm);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{idx: 0, ox: 80,  oy: 60,  col: 3'b100, plots: 100};
        vecs[1] = '{idx: 1, ox: 155, oy: 115, col: 3'b010, plots: 25};
        vecs[2] = '{idx: 2, ox: 0,   oy: 0,   col: 3'b111, plots: 100};
        vecs[3] = '{idx: 0, ox: 150, oy: 5,   col: 3'b001, plots: 100};
        vecs[4] = '{idx: 2, ox: 158, oy: 119, col: 3'b011, plots: 2};
        vecs[5] = '{idx: 1, ox: 255, oy: 0,   col: 3'b101, plots: 0};
        vecs[6] = '{idx: 0, ox: 20,  oy: 127, col: 3'b110, plots: 0};

        // Reset with all three requesting, then round-robin contention.
        Resetn         = 1'b0;
        bus.req        = 3'b000;
        bus.req_x      = {8'd50, 8'd30, 8'd10};
        bus.req_y      = {7'd30, 7'd20, 7'd10};
        bus.req_colour = {3'b011, 3'b010, 3'b001};
        push_square(10, 10, 3'b001, 100);
        push_square(30, 20, 3'b010, 100);
        push_square(50, 30, 3'b011, 100);
        exp_done.push_back(3'b001);
        exp_done.push_back(3'b010);
        exp_done.push_back(3'b100);
        bus.req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("reset_outputs", {bus.grant, bus.done, bus.busy, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
        end
        Resetn = 1'b1;
        @(negedge Clock);
        chk("rst_release_grant", {29'b0, bus.grant}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            gstart[i] = 0;
            gval[i]   = 3'b000;
        end
        ng     = 0;
        prev_g = 3'b000;
        fin    = 0;
        for (int n = 0; n < 600 && !fin; n++) begin
            if (bus.grant != 3'b000 && bus.grant != prev_g && ng < 3) begin
                gstart[ng] = n;
                gval[ng]   = bus.grant;
                ng++;
            end
            prev_g = bus.grant;
            if (bus.done != 3'b000) begin
                bus.req = bus.req & ~bus.done;
                if (bus.done[2]) fin = 1;
            end
            @(negedge Clock);
        end
        if (!fin) begin
            checks++;
            errs++;
            $display("FAIL contention_timeout: got no done[2] expected one within 600 cycles");
        end
        chk("contention_count", ng, 32'd3);
        chk("contention_g0", {29'b0, gval[0]}, 32'b001);
        chk("contention_g1", {29'b0, gval[1]}, 32'b010);
        chk("contention_g2", {29'b0, gval[2]}, 32'b100);
        chk("contention_gap01", gstart[1] - gstart[0], 32'd102);
        chk("contention_gap12", gstart[2] - gstart[1], 32'd102);
        chk("contention_idle", {29'b0, bus.grant}, 32'd0);
        chk("contention_queue", exp_pix.size() + exp_done.size(), 32'd0);

        // Single fills from the table.
        for (int i = 0; i < 7; i++) begin
            run_fill(vecs[i].idx, vecs[i].ox, vecs[i].oy, vecs[i].col, vecs[i].plots, -1,
                     $sformatf("vec%0d", i));
        end

        // Reset abort at fill cycle 37, then re-grant of the held request.
        @(negedge Clock);
        bus.req_x[7:0]      = 8'd20;
        bus.req_y[6:0]      = 7'd40;
        bus.req_colour[2:0] = 3'b101;
        push_square(20, 40, 3'b101, 37);
        bus.req[0] = 1'b1;
        @(negedge Clock);
        chk("abort_grant", {29'b0, bus.grant}, 32'd1);
        repeat (36) @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        chk("abort_outputs", {24'b0, bus.grant, bus.done, bus.busy, bus.plot}, 32'd0);
        chk("abort_pixels", exp_pix.size(), 32'd0);
        push_square(20, 40, 3'b101, 100);
        exp_done.push_back(3'b001);
        Resetn = 1'b1;
        @(negedge Clock);
        chk("abort_regrant", {29'b0, bus.grant}, 32'd1);
        track_fill(0, 100, -1, "regrant");

        // Inputs change and req drops mid-fill; latched values must persist.
        run_fill(2, 100, 50, 3'b011, 100, 20, "midchange");
        repeat (3) @(negedge Clock);
        chk("midchange_no_regrant", {29'b0, bus.grant}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
